// File: rtl/ir_camera_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ir_camera_tracker
// Description : Brings a Wii-style IR camera out of reset, configures it in
//               extended mode over the shared i2c_master and polls it at a
//               fixed period. Each poll decodes up to four blobs into
//               registered coordinates, sizes and valid flags. Any handshake
//               phase that stalls for TIMEOUT_CYCLES sets a sticky error
//               flag and returns the block to idle.
// Ports       : clk, reset (async, active high), run (level enable)
//               i2c_ready, i2c_data_out             <- i2c_master
//               i2c_start, i2c_addr, i2c_rw,
//               i2c_packets, i2c_data               -> i2c_master
//               cam_reset (active low)              -> camera
//               blob_x/_y/_size/_valid, frame_valid,
//               frame_count, initialised, error     -> tracking logic
// Revision    : 1.0 - initial release
// ============================================================================
module ir_camera_tracker #(
    parameter int          NUM_BLOBS      = 4,
    parameter logic [6:0]  I2C_ADDR       = 7'h58,
    parameter logic [71:0] SENS_BLOCK1    = 72'h02_00_00_71_01_00_AA_00_64,
    parameter logic [15:0] SENS_BLOCK2    = 16'h63_03,
    parameter int          RESET_CYCLES   = 100,
    parameter int          POLL_CYCLES    = 1000,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   i2c_ready,
    input  logic [127:0]           i2c_data_out,
    output logic                   i2c_start,
    output logic [6:0]             i2c_addr,
    output logic                   i2c_rw,
    output logic [4:0]             i2c_packets,
    output logic [127:0]           i2c_data,
    output logic                   cam_reset,
    output logic [NUM_BLOBS*10-1:0] blob_x,
    output logic [NUM_BLOBS*10-1:0] blob_y,
    output logic [NUM_BLOBS*4-1:0]  blob_size,
    output logic [NUM_BLOBS-1:0]    blob_valid,
    output logic                   frame_valid,
    output logic [15:0]            frame_count,
    output logic                   initialised,
    output logic                   error
);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_RST_HOLD = 3'd1;
    localparam logic [2:0] c_S_ISSUE    = 3'd2;
    localparam logic [2:0] c_S_WAIT     = 3'd3;
    localparam logic [2:0] c_S_POLL     = 3'd4;
    localparam logic [2:0] c_S_DECODE   = 3'd5;

    // Transaction steps: 0..4 configuration writes, then the poll pair.
    localparam logic [2:0] c_STEP_LAST_CFG = 3'd4;
    localparam logic [2:0] c_STEP_REQ      = 3'd5;
    localparam logic [2:0] c_STEP_RD       = 3'd6;

    localparam logic [31:0] c_RST_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] c_POLL_LAST = 32'(POLL_CYCLES - 1);
    localparam logic [31:0] c_TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]   r_state;
    logic [2:0]   r_step;
    logic [31:0]  r_cnt;
    logic         r_i2c_start;
    logic         r_i2c_rw;
    logic [4:0]   r_i2c_packets;
    logic [127:0] r_i2c_data;
    logic         r_cam_reset;
    logic [NUM_BLOBS*10-1:0] r_blob_x;
    logic [NUM_BLOBS*10-1:0] r_blob_y;
    logic [NUM_BLOBS*4-1:0]  r_blob_size;
    logic [NUM_BLOBS-1:0]    r_blob_valid;
    logic         r_frame_valid;
    logic [15:0]  r_frame_count;
    logic         r_initialised;
    logic         r_error;

    logic [2:0]   w_ld_step;
    logic [127:0] w_ld_data;
    logic [4:0]   w_ld_pkts;
    logic         w_ld_rw;
    logic         w_phase_done;
    logic         w_timeout;
    logic [NUM_BLOBS*10-1:0] w_dec_x;
    logic [NUM_BLOBS*10-1:0] w_dec_y;
    logic [NUM_BLOBS*4-1:0]  w_dec_size;
    logic [NUM_BLOBS-1:0]    w_dec_valid;
    logic         w_unused_bytes;

    // Step that the next ISSUE entry will carry, and its request payload.
    // Payloads are right-aligned so the first byte sits at [P*8-1 -: 8].
    always_comb begin
        w_ld_step = 3'd0;
        if (r_state == c_S_WAIT)
            w_ld_step = r_step + 3'd1;
        else if (r_state == c_S_POLL)
            w_ld_step = c_STEP_REQ;
        w_ld_data = 128'h0;
        w_ld_pkts = 5'd0;
        w_ld_rw   = 1'b0;
        case (w_ld_step)
            3'd0: begin w_ld_data[15:0] = 16'h3001;              w_ld_pkts = 5'd2;  end
            3'd1: begin w_ld_data[79:0] = {8'h00, SENS_BLOCK1};  w_ld_pkts = 5'd10; end
            3'd2: begin w_ld_data[23:0] = {8'h1A, SENS_BLOCK2};  w_ld_pkts = 5'd3;  end
            3'd3: begin w_ld_data[15:0] = 16'h3303;              w_ld_pkts = 5'd2;  end
            3'd4: begin w_ld_data[15:0] = 16'h3008;              w_ld_pkts = 5'd2;  end
            c_STEP_REQ: begin w_ld_data[7:0] = 8'h36;            w_ld_pkts = 5'd1;  end
            c_STEP_RD:  begin w_ld_rw = 1'b1;                    w_ld_pkts = 5'd16; end
            default: ;
        endcase
    end

    // Acceptance only counts once start is actually on the bus, so a ready
    // that is still low from elsewhere cannot be mistaken for acceptance.
    assign w_phase_done = ((r_state == c_S_ISSUE) && r_i2c_start && !i2c_ready) ||
                          ((r_state == c_S_WAIT) && i2c_ready);
    assign w_timeout    = ((r_state == c_S_ISSUE) || (r_state == c_S_WAIT)) &&
                          !w_phase_done && (r_cnt == c_TO_LAST);

    // Blob i occupies read bytes 1+3i..3+3i; byte k is at [(15-k)*8 +: 8].
    for (genvar gi = 0; gi < NUM_BLOBS; gi++) begin : g_blob
        logic [7:0] w_b0;
        logic [7:0] w_b1;
        logic [7:0] w_b2;
        assign w_b0 = i2c_data_out[(14 - 3*gi)*8 +: 8];
        assign w_b1 = i2c_data_out[(13 - 3*gi)*8 +: 8];
        assign w_b2 = i2c_data_out[(12 - 3*gi)*8 +: 8];
        assign w_dec_x[gi*10 +: 10]  = {w_b2[5:4], w_b0};
        assign w_dec_y[gi*10 +: 10]  = {w_b2[7:6], w_b1};
        assign w_dec_size[gi*4 +: 4] = w_b2[3:0];
        // The camera reports an empty slot as x = y = 1023.
        assign w_dec_valid[gi] = !(({w_b2[5:4], w_b0} == 10'h3FF) &&
                                   ({w_b2[7:6], w_b1} == 10'h3FF));
    end

    // Header byte and trailing bytes of the read are not blob data.
    assign w_unused_bytes = ^{i2c_data_out[127:120],
                              i2c_data_out[(15 - 3*NUM_BLOBS)*8-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_S_IDLE;
            r_step        <= 3'd0;
            r_cnt         <= 32'd0;
            r_i2c_start   <= 1'b0;
            r_i2c_rw      <= 1'b0;
            r_i2c_packets <= 5'd0;
            r_i2c_data    <= 128'h0;
            r_cam_reset   <= 1'b0;
            r_blob_x      <= '0;
            r_blob_y      <= '0;
            r_blob_size   <= '0;
            r_blob_valid  <= '0;
            r_frame_valid <= 1'b0;
            r_frame_count <= 16'd0;
            r_initialised <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if (w_timeout) begin
                r_error       <= 1'b1;
                r_initialised <= 1'b0;
                r_i2c_start   <= 1'b0;
                r_cam_reset   <= 1'b0;
                r_state       <= c_S_IDLE;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        r_cam_reset   <= 1'b0;
                        r_initialised <= 1'b0;
                        if (run && i2c_ready) begin
                            r_error <= 1'b0;
                            r_cnt   <= 32'd0;
                            r_state <= c_S_RST_HOLD;
                        end
                    end
                    c_S_RST_HOLD: begin
                        if (!run) begin
                            r_state <= c_S_IDLE;
                        end else if (r_cnt == c_RST_LAST) begin
                            r_cam_reset   <= 1'b1;
                            r_step        <= w_ld_step;
                            r_i2c_data    <= w_ld_data;
                            r_i2c_packets <= w_ld_pkts;
                            r_i2c_rw      <= w_ld_rw;
                            r_cnt         <= 32'd0;
                            r_state       <= c_S_ISSUE;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    c_S_ISSUE: begin
                        if (w_phase_done) begin
                            r_i2c_start <= 1'b0;
                            r_cnt       <= 32'd0;
                            r_state     <= c_S_WAIT;
                        end else begin
                            r_i2c_start <= 1'b1;
                            r_cnt       <= r_cnt + 32'd1;
                        end
                    end
                    c_S_WAIT: begin
                        if (w_phase_done) begin
                            if (r_step == c_STEP_RD) begin
                                // A started read is always decoded.
                                r_state <= c_S_DECODE;
                            end else if (!run) begin
                                r_initialised <= 1'b0;
                                r_state       <= c_S_IDLE;
                            end else if (r_step == c_STEP_LAST_CFG) begin
                                r_initialised <= 1'b1;
                                r_cnt         <= 32'd0;
                                r_state       <= c_S_POLL;
                            end else begin
                                r_step        <= w_ld_step;
                                r_i2c_data    <= w_ld_data;
                                r_i2c_packets <= w_ld_pkts;
                                r_i2c_rw      <= w_ld_rw;
                                r_cnt         <= 32'd0;
                                r_state       <= c_S_ISSUE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    c_S_POLL: begin
                        if (!run) begin
                            r_initialised <= 1'b0;
                            r_state       <= c_S_IDLE;
                        end else if (r_cnt == c_POLL_LAST) begin
                            r_step        <= w_ld_step;
                            r_i2c_data    <= w_ld_data;
                            r_i2c_packets <= w_ld_pkts;
                            r_i2c_rw      <= w_ld_rw;
                            r_cnt         <= 32'd0;
                            r_state       <= c_S_ISSUE;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    c_S_DECODE: begin
                        r_blob_x      <= w_dec_x;
                        r_blob_y      <= w_dec_y;
                        r_blob_size   <= w_dec_size;
                        r_blob_valid  <= w_dec_valid;
                        r_frame_valid <= 1'b1;
                        r_frame_count <= r_frame_count + 16'd1;
                        r_cnt         <= 32'd0;
                        if (run) begin
                            r_state <= c_S_POLL;
                        end else begin
                            r_initialised <= 1'b0;
                            r_state       <= c_S_IDLE;
                        end
                    end
                    default: r_state <= c_S_IDLE;
                endcase
            end
        end
    end

    assign i2c_start   = r_i2c_start;
    assign i2c_addr    = I2C_ADDR;
    assign i2c_rw      = r_i2c_rw;
    assign i2c_packets = r_i2c_packets;
    assign i2c_data    = r_i2c_data;
    assign cam_reset   = r_cam_reset;
    assign blob_x      = r_blob_x;
    assign blob_y      = r_blob_y;
    assign blob_size   = r_blob_size;
    assign blob_valid  = r_blob_valid;
    assign frame_valid = r_frame_valid;
    assign frame_count = r_frame_count;
    assign initialised = r_initialised;
    assign error       = r_error;

endmodule
`default_nettype wire

// File: doc/ir_camera_tracker.md
# ir_camera_tracker

Parametrised successor to the single-point IR camera driver. It initialises a Wii-style IR camera (I2C address 0x58) in extended mode through the shared `i2c_master` and polls it at a fixed period. Each poll decodes up to four blobs into registered coordinates, sizes and valid flags for the downstream drawing and tracking logic. It also adds transaction timeout detection, a run/stop control and a frame counter.

## Interface
Parameters:
- NUM_BLOBS, 4, blobs decoded per frame (1–4).
- I2C_ADDR, 7'h58, camera address.
- SENS_BLOCK1, 72'h02_00_00_71_01_00_AA_00_64, sensitivity block written at register 0x00.
- SENS_BLOCK2, 16'h63_03, sensitivity block written at register 0x1A.
- RESET_CYCLES, 100, clocks cam_reset is held low before configuration.
- POLL_CYCLES, 1000, clocks from frame decode to next poll.
- TIMEOUT_CYCLES, 65535, maximum clocks per I2C handshake phase.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = initialise and poll, 0 = return to idle.
- i2c_ready  in  1  from i2c_master.
- i2c_data_out  in  128  read data; byte k at [(15-k)*8 +: 8].
- i2c_start  out  1  to i2c_master.
- i2c_addr  out  7  constant I2C_ADDR.
- i2c_rw  out  1  1 = read.
- i2c_packets  out  5  byte count.
- i2c_data  out  128  write bytes, right-aligned; first byte at [P*8-1 -: 8].
- cam_reset  out  1  active-low camera reset.
- blob_x  out  NUM_BLOBS*10  blob i at [i*10 +: 10].
- blob_y  out  NUM_BLOBS*10  same packing.
- blob_size  out  NUM_BLOBS*4  blob i at [i*4 +: 4].
- blob_valid  out  NUM_BLOBS  per-blob valid.
- frame_valid  out  1  one-cycle pulse on output update.
- frame_count  out  16  frames decoded, wraps at 0xFFFF.
- initialised  out  1  configuration completed.
- error  out  1  sticky timeout flag.

## Operation
- All outputs reset to 0, including cam_reset (camera held in reset). State resets to IDLE.
- IDLE: cam_reset = 0. When run = 1 and i2c_ready = 1: clear error, go to RST_HOLD.
- RST_HOLD: hold for RESET_CYCLES, then cam_reset <= 1 and go to CFG with step = 0.
- CFG: write steps, each one I2C transaction:
  - 0: 30 01 (P = 2)
  - 1: 00 + SENS_BLOCK1 (P = 10)
  - 2: 1A + SENS_BLOCK2 (P = 3)
  - 3: 33 03 (P = 2)
  - 4: 30 08 (P = 2)
- After step 4: initialised <= 1, go to POLL_DELAY.
- POLL_DELAY: count POLL_CYCLES. Next state is REQ, write 36 (P = 1), then RD, read (P = 16, rw = 1), then DECODE.
- Transaction handshake, shared by all steps:
  - ISSUE: hold i2c_start = 1 with data, packets and rw stable, until i2c_ready = 0 (accepted).
  - WAIT: i2c_start = 0 until i2c_ready = 1 (done).
  - data, packets and rw stay stable from ISSUE entry until WAIT exit.
- DECODE: for blob i, b0..b2 = bytes 1+3i .. 3+3i.
  - x = {b2[5:4], b0}; y = {b2[7:6], b1}; size = b2[3:0].
  - valid = !(x == 1023 && y == 1023).
  - All blob outputs are written in the same cycle, including invalid blobs. frame_valid pulses, frame_count increments, then go to POLL_DELAY.
- Timeout: a counter restarts at each ISSUE and WAIT entry. Reaching TIMEOUT_CYCLES in either phase forces:
  - error <= 1, initialised <= 0, i2c_start <= 0, cam_reset <= 0
  - go to IDLE; blob outputs are held.
- run = 0:
  - In POLL_DELAY, RST_HOLD or IDLE: go to IDLE immediately. initialised is cleared.
  - During a transaction: complete it, including DECODE, then go to IDLE instead of POLL_DELAY or the next CFG step.
- Asynchronous reset mid-transaction: everything returns to reset values immediately. i2c_start drops in the same instant.

## Timing
- i2c_start, data, packets and rw are registered outputs.
- i2c_start rises the cycle after ISSUE entry.
- The ready-low to i2c_start-low gap is 1 cycle.
- Read completion (i2c_ready high in RD WAIT) to blob outputs and frame_valid: 2 cycles (WAIT to DECODE, then registered update).
- Poll period is POLL_CYCLES plus the REQ and RD transaction times plus 2.
- frame_count 0xFFFF + 1 = 0x0000, with no flag.
- Simultaneous run = 0 and timeout: timeout wins (error set).

## Test plan
- **Init sequence.** i2c_master BFM, run = 1.
  - Required: cam_reset low for 100 cycles, then the five writes in order (30 01; 00 02 00 00 71 01 00 AA 00 64; 1A 63 03; 33 03; 30 08) with P = 2, 10, 3, 2, 2.
  - Then initialised = 1.
- **Decode.**
  - BFM returns bytes 1..3 = 45 23 A7 and bytes 4..12 = FF.
  - Required: blob0 x = 0x245, y = 0x223, size = 7, valid = 1; blobs 1–3 valid = 0.
  - Required: frame_valid pulse once, frame_count = 1.
- **Handshake.** BFM delays ready-low 5 cycles.
  - Required: i2c_start held high exactly until ready falls; data stable throughout.
- **Timeout.** BFM never drops ready on step 2.
  - Required: after 65535 cycles, error = 1, cam_reset = 0, IDLE.
  - Then re-raise run: error clears and init restarts.
- **Run drop mid-read.** run = 0 during RD WAIT.
  - Required: frame still decodes, then IDLE with initialised = 0.
- **Reset mid-CFG.** Assert reset during step 1 ISSUE.
  - Required: i2c_start and all outputs are 0 asynchronously.
